// File: rtl/calendar_date_ctrl.sv
// Date section of the digital clock: day/month sequencing with month
// lengths, leap February, and a month-then-date set mode with date clamp.
module calendar_date_ctrl #(
    parameter bit LEAP_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       day_tick,
    input  logic       leap_year,
    input  logic       set_req,
    input  logic       set_next,
    input  logic       set_inc,
    output logic [3:0] month,
    output logic [5:0] date,
    output logic [5:0] month_days,
    output logic       month_tick,
    output logic       year_tick,
    output logic [1:0] mode
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_MON = 2'd1,
        SET_DAY = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] month_q, month_d;
    logic [5:0] date_q, date_d;
    logic       month_tick_q, month_tick_d;
    logic       year_tick_q, year_tick_d;
    logic       set_req_q, set_req_d;
    logic       set_rise_q, set_rise_d;
    logic [3:0] month_inc;
    logic [5:0] date_clamp;

    always_comb begin
        unique case (month_q)
            4'd2:                      month_days = (LEAP_EN && leap_year) ? 6'd29 : 6'd28;
            4'd4, 4'd6, 4'd9, 4'd11:   month_days = 6'd30;
            default:                   month_days = 6'd31;
        endcase
    end

    assign month_inc  = (month_q >= 4'd12) ? 4'd1 : month_q + 4'd1;
    assign date_clamp = (date_q > month_days) ? month_days : date_q;

    always_comb begin
        state_d      = state_q;
        month_d      = month_q;
        date_d       = date_q;
        month_tick_d = 1'b0;
        year_tick_d  = 1'b0;
        set_req_d    = set_req;
        // Rise is registered so entry into set mode lands one edge later.
        set_rise_d   = set_req & ~set_req_q;
        unique case (state_q)
            RUN: begin
                if (day_tick) begin
                    if (date_q >= month_days) begin
                        date_d       = 6'd1;
                        month_d      = month_inc;
                        month_tick_d = 1'b1;
                        year_tick_d  = (month_q >= 4'd12);
                    end else begin
                        date_d = date_q + 6'd1;
                    end
                end
                if (set_rise_q) state_d = SET_MON;
            end
            SET_MON: begin
                if (!set_req || set_next) begin
                    state_d = set_req ? SET_DAY : RUN;
                    date_d  = date_clamp;
                end else if (set_inc) begin
                    month_d = month_inc;
                end
            end
            SET_DAY: begin
                if (!set_req || set_next) begin
                    state_d = RUN;
                end else if (set_inc) begin
                    date_d = (date_q >= month_days) ? 6'd1 : date_q + 6'd1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= RUN;
            month_q      <= 4'd1;
            date_q       <= 6'd1;
            month_tick_q <= 1'b0;
            year_tick_q  <= 1'b0;
            set_req_q    <= 1'b0;
            set_rise_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            month_q      <= month_d;
            date_q       <= date_d;
            month_tick_q <= month_tick_d;
            year_tick_q  <= year_tick_d;
            set_req_q    <= set_req_d;
            set_rise_q   <= set_rise_d;
        end
    end

    assign month      = month_q;
    assign date       = date_q;
    assign month_tick = month_tick_q;
    assign year_tick  = year_tick_q;
    assign mode       = state_q;

endmodule
